// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word and memory-controller state encoding.
// Imported by the cache/memory side of the core.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DRD,
    DWR
  } memctrl_state_t;

endpackage

// File: rtl/cache_mem_ctrl.sv
// Arbitrates icache fills and dcache reads/writes onto one single-port RAM.
// Ports: CLK/RST, icache (iREN,iaddr,iwait,iload), dcache (dREN,dWEN,daddr,
//   dstore,dwait,dload), RAM (ramaddr,ramstore,ramREN,ramWEN,ramload,ramready).
module cache_mem_ctrl
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  iwait,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dwait,
  output word_t dload,
  output word_t ramaddr,
  output word_t ramstore,
  output logic  ramREN,
  output logic  ramWEN,
  input  word_t ramload,
  input  logic  ramready
);

  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

  memctrl_state_t   state;
  logic [CNT_W-1:0] starve_cnt;

  logic dreq;
  logic starved;
  logic gnt_d;

  // Data normally wins; a pending fetch that has watched SMAX data
  // grants in a row takes the next slot instead.
  always_comb begin
    dreq    = dREN | dWEN;
    starved = iREN && (starve_cnt == SMAX);
    gnt_d   = dreq && !starved;
  end

  assign iload = ramload;
  assign dload = ramload;

  assign iwait = !((state == IACC) && ramready);
  assign dwait = !(((state == DRD) || (state == DWR)) && ramready);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ramaddr    <= '0;
      ramstore   <= '0;
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_d) begin
            ramaddr <= daddr;
            // Write wins when both dREN and dWEN are up.
            if (dWEN) begin
              ramstore <= dstore;
              state    <= DWR;
              ramWEN   <= 1'b1;
            end else begin
              state  <= DRD;
              ramREN <= 1'b1;
            end
            if (!iREN)
              starve_cnt <= '0;
            else if (starve_cnt != SMAX)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (iREN) begin
            ramaddr    <= iaddr;
            state      <= IACC;
            ramREN     <= 1'b1;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        IACC: begin
          // Requester dropping iREN abandons the fill silently.
          if (ramready || !iREN) begin
            state  <= IDLE;
            ramREN <= 1'b0;
          end
        end
        DRD: begin
          if (ramready || !dREN) begin
            state  <= IDLE;
            ramREN <= 1'b0;
          end
        end
        DWR: begin
          // Writes always run to completion.
          if (ramready) begin
            state  <= IDLE;
            ramWEN <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: vector table plus multi-cycle sequences.
// Prints one summary line with comparison and miscompare counts.
module tb_cache_mem_ctrl;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dwait;
  word_t dload;
  word_t ramaddr;
  word_t ramstore;
  logic  ramREN;
  logic  ramWEN;
  word_t ramload;
  logic  ramready;

  cache_mem_ctrl #(.STARVE_MAX(8), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramready(ramready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  ir;
    word_t ia;
    logic  dr;
    logic  dw;
    word_t da;
    word_t ds;
    logic  rr;
    word_t rl;
    logic  e_iw;
    logic  e_dw;
    logic  e_re;
    logic  e_we;
    word_t e_ra;
    word_t e_rs;
  } vec_t;

  vec_t vecs[$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ir, input word_t ia, input logic dr,
                     input logic dw, input word_t da, input word_t ds,
                     input logic rr, input word_t rl, input logic e_iw,
                     input logic e_dw, input logic e_re, input logic e_we,
                     input word_t e_ra, input word_t e_rs);
    vec_t v;
    v = '{ir, ia, dr, dw, da, ds, rr, rl, e_iw, e_dw, e_re, e_we, e_ra, e_rs};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ir, input word_t ia, input logic dr,
                       input logic dw, input word_t da, input word_t ds,
                       input logic rr, input word_t rl);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramready = rr; ramload = rl;
  endtask

  int dcnt;
  int icomp;
  bit done;

  initial begin
    // fill/idle
    add(1, 32'h40, 0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 32'h0,   32'h0);
    add(1, 32'h40, 0, 0, 0, 0, 0, 0,            1, 1, 1, 0, 32'h40,  32'h0);
    add(1, 32'h40, 0, 0, 0, 0, 0, 0,            1, 1, 1, 0, 32'h40,  32'h0);
    add(1, 32'h40, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1, 1, 0, 32'h40,  32'h0);
    add(0, 0,      0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 32'h40,  32'h0);
    // contention: write first, bubble, then fetch
    add(1, 32'h80, 0, 1, 32'h100, 32'h12345678, 1, 0,
        1, 1, 0, 0, 32'h40,  32'h0);
    add(1, 32'h80, 0, 1, 32'h100, 32'h12345678, 1, 0,
        1, 0, 0, 1, 32'h100, 32'h12345678);
    add(1, 32'h80, 0, 0, 0, 0, 1, 0,            1, 1, 0, 0, 32'h100, 32'h12345678);
    add(1, 32'h80, 0, 0, 0, 0, 1, 32'h11,       0, 1, 1, 0, 32'h80,  32'h12345678);
    // read+write together runs as write; ramready ignored in IDLE
    add(0, 0, 1, 1, 32'h200, 32'hCAFEF00D, 1, 0,
        1, 1, 0, 0, 32'h80,  32'h12345678);
    add(0, 0, 1, 1, 32'h200, 32'hCAFEF00D, 1, 0,
        1, 0, 0, 1, 32'h200, 32'hCAFEF00D);
    add(0, 0,      0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 32'h200, 32'hCAFEF00D);
    // stalled data read
    add(0, 0, 1, 0, 32'h300, 0, 0, 0,           1, 1, 0, 0, 32'h200, 32'hCAFEF00D);
    add(0, 0, 1, 0, 32'h300, 0, 0, 0,           1, 1, 1, 0, 32'h300, 32'hCAFEF00D);
    add(0, 0, 1, 0, 32'h300, 0, 1, 32'h0BADF00D,
        1, 0, 1, 0, 32'h300, 32'hCAFEF00D);
    add(0, 0,      0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 32'h300, 32'hCAFEF00D);

    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_iwait", 32'(iwait), 32'h1);
    chk("rst_dwait", 32'(dwait), 32'h1);
    chk("rst_ramREN", 32'(ramREN), 32'h0);
    chk("rst_ramWEN", 32'(ramWEN), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw,
            vecs[i].da, vecs[i].ds, vecs[i].rr, vecs[i].rl);
      #1;
      chk($sformatf("v%0d_iwait", i), 32'(iwait), 32'(vecs[i].e_iw));
      chk($sformatf("v%0d_dwait", i), 32'(dwait), 32'(vecs[i].e_dw));
      chk($sformatf("v%0d_ramREN", i), 32'(ramREN), 32'(vecs[i].e_re));
      chk($sformatf("v%0d_ramWEN", i), 32'(ramWEN), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_ramaddr", i), ramaddr, vecs[i].e_ra);
      chk($sformatf("v%0d_ramstore", i), ramstore, vecs[i].e_rs);
      chk($sformatf("v%0d_iload", i), iload, vecs[i].rl);
      chk($sformatf("v%0d_dload", i), dload, vecs[i].rl);
      @(negedge CLK);
    end

    // fill aborted in its second busy cycle
    drive(1, 32'h44, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #1 chk("abt_c1_ramREN", 32'(ramREN), 32'h1);
    @(negedge CLK);
    iREN = 1'b0;
    #1 chk("abt_c2_ramREN", 32'(ramREN), 32'h1);
    chk("abt_c2_iwait", 32'(iwait), 32'h1);
    @(negedge CLK);
    #1 chk("abt_c3_ramREN", 32'(ramREN), 32'h0);
    chk("abt_c3_iwait", 32'(iwait), 32'h1);

    // write held after dWEN drops
    drive(0, 0, 0, 1, 32'h50, 32'h77, 0, 0);
    @(negedge CLK);
    #1 chk("wh_c1_ramWEN", 32'(ramWEN), 32'h1);
    chk("wh_c1_ramaddr", ramaddr, 32'h50);
    chk("wh_c1_ramstore", ramstore, 32'h77);
    @(negedge CLK);
    dWEN = 1'b0;
    #1 chk("wh_c2_ramWEN", 32'(ramWEN), 32'h1);
    chk("wh_c2_dwait", 32'(dwait), 32'h1);
    @(negedge CLK);
    ramready = 1'b1;
    #1 chk("wh_c3_ramWEN", 32'(ramWEN), 32'h1);
    chk("wh_c3_dwait", 32'(dwait), 32'h0);
    @(negedge CLK);
    ramready = 1'b0;
    #1 chk("wh_c4_ramWEN", 32'(ramWEN), 32'h0);
    chk("wh_c4_dwait", 32'(dwait), 32'h1);

    // starvation: both held, RAM always ready
    @(negedge CLK);
    drive(1, 32'h500, 1, 0, 32'h600, 0, 1, 0);
    dcnt = 0;
    icomp = 0;
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (!dwait) dcnt++;
      if (!iwait) begin
        icomp++;
        chk($sformatf("starve_dcomp_%0d", icomp), 32'(dcnt), 32'd8);
        chk($sformatf("starve_iaddr_%0d", icomp), ramaddr, 32'h500);
        dcnt = 0;
        if (icomp == 2) done = 1;
      end
      @(negedge CLK);
    end
    chk("starve_icomps", 32'(icomp), 32'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);

    // asynchronous reset in the middle of a write
    drive(0, 0, 0, 1, 32'h70, 32'h99, 0, 0);
    @(negedge CLK);
    #1 chk("mrst_pre_ramWEN", 32'(ramWEN), 32'h1);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk("mrst_ramWEN", 32'(ramWEN), 32'h0);
    chk("mrst_ramREN", 32'(ramREN), 32'h0);
    chk("mrst_iwait", 32'(iwait), 32'h1);
    chk("mrst_dwait", 32'(dwait), 32'h1);
    chk("mrst_ramaddr", ramaddr, 32'h0);
    chk("mrst_ramstore", ramstore, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #1 chk("post_rst_ramWEN", 32'(ramWEN), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
